// File: rtl/serial_pkg.sv
// Shared constants, state encodings and bit-period helper for the serial RX loader.
// Pure declarations: no latency, no flow control.
package serial_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {HUNT, ADDR, DATA, CHK, WRITE} parser_state_t;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
// rx_valid/frame_err pulse at the stop-bit centre (~9.5 bit periods + 2 cycles); no backpressure.
module uart_rx_core
   import serial_pkg::*;
#(
   parameter int DIV = 217
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam logic [15:0] BIT_END  = 16'(DIV - 1);
   localparam logic [15:0] HALF_END = 16'(DIV / 2 - 1);

   logic        sync1, sync2, prev;
   rx_state_t   state, state_nxt;
   logic [15:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        cnt_clr, take_bit, done_ok, done_bad;

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      take_bit  = 1'b0;
      done_ok   = 1'b0;
      done_bad  = 1'b0;
      case (state)
         RX_IDLE: begin
            if (prev && !sync2) begin
               state_nxt = RX_START;
               cnt_clr   = 1'b1;
            end
         end
         RX_START: begin
            // a line that is high again at half a bit is a glitch, not a start bit
            if (cnt == HALF_END) begin
               cnt_clr   = 1'b1;
               state_nxt = sync2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt == BIT_END) begin
               cnt_clr  = 1'b1;
               take_bit = 1'b1;
               if (bit_idx == 3'd7) state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt == BIT_END) begin
               cnt_clr   = 1'b1;
               state_nxt = RX_IDLE;
               done_ok   = sync2;
               done_bad  = !sync2;
            end
         end
         default: state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         prev      <= 1'b1;
         state     <= RX_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         rx_valid  <= 1'b0;
         rx_byte   <= '0;
         frame_err <= 1'b0;
      end else begin
         sync1     <= rxd;
         sync2     <= sync1;
         prev      <= sync2;
         state     <= state_nxt;
         cnt       <= (cnt_clr || state == RX_IDLE) ? 16'd0 : cnt + 16'd1;
         if (state == RX_START) bit_idx <= 3'd0;
         else if (take_bit)     bit_idx <= bit_idx + 3'd1;
         if (take_bit) shift <= {sync2, shift[7:1]};
         rx_valid  <= done_ok;
         frame_err <= done_bad;
         if (done_ok) rx_byte <= shift;
      end
   end

endmodule

// File: rtl/serial_rx_loader.sv
// UART frame parser turning A5/addr[3]/data[4] frames into one RAM word write; optional checksum under SERIAL_RX_CHECKSUM_EN.
// wr_en rises 1 cycle after the last byte's rx_valid; no backpressure (the RAM port always accepts).
module serial_rx_loader
   import serial_pkg::*;
#(
   parameter int CLK_HZ       = 25000000,
   parameter int BAUD         = 115200,
   parameter int ADDR_W       = 17,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rxd,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              rx_valid,
   output logic [7:0]        rx_byte,
   output logic              busy,
   output logic              frame_err,
   output logic              chk_err
);

   localparam int          DIV       = calc_div(CLK_HZ, BAUD);
   localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_BITS * DIV);

   parser_state_t     state, state_nxt;
   logic [1:0]        idx, idx_nxt;
   logic [ADDR_W-1:0] addr_sh, addr_nxt;
   logic [31:0]       data_sh, data_nxt;
   logic [31:0]       tmo;
   logic              tmo_exp;
`ifdef SERIAL_RX_CHECKSUM_EN
   logic [7:0]        chk_acc, chk_nxt;
   logic              chk_fail, chk_err_q;
`endif

   uart_rx_core #(.DIV(DIV)) u_core (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .frame_err (frame_err)
   );

   assign tmo_exp = (tmo == TMO_LIMIT);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      addr_nxt  = addr_sh;
      data_nxt  = data_sh;
`ifdef SERIAL_RX_CHECKSUM_EN
      chk_nxt   = chk_acc;
      chk_fail  = 1'b0;
`endif
      if (state == WRITE) begin
         state_nxt = HUNT;
      end else if (frame_err) begin
         state_nxt = HUNT;
      end else if (rx_valid) begin
         // a byte arriving in the same cycle as the timeout takes priority
         case (state)
            HUNT: begin
               if (rx_byte == SYNC_BYTE) begin
                  state_nxt = ADDR;
                  idx_nxt   = 2'd0;
`ifdef SERIAL_RX_CHECKSUM_EN
                  chk_nxt   = 8'd0;
`endif
               end
            end
            ADDR: begin
               addr_nxt = {addr_sh[ADDR_W-9:0], rx_byte};
               idx_nxt  = idx + 2'd1;
`ifdef SERIAL_RX_CHECKSUM_EN
               chk_nxt  = chk_acc ^ rx_byte;
`endif
               if (idx == 2'd2) begin
                  state_nxt = DATA;
                  idx_nxt   = 2'd0;
               end
            end
            DATA: begin
               data_nxt = {rx_byte, data_sh[31:8]};
               idx_nxt  = idx + 2'd1;
`ifdef SERIAL_RX_CHECKSUM_EN
               chk_nxt  = chk_acc ^ rx_byte;
               if (idx == 2'd3) state_nxt = CHK;
`else
               if (idx == 2'd3) state_nxt = WRITE;
`endif
            end
            CHK: begin
`ifdef SERIAL_RX_CHECKSUM_EN
               if (rx_byte == chk_acc) begin
                  state_nxt = WRITE;
               end else begin
                  state_nxt = HUNT;
                  chk_fail  = 1'b1;
               end
`else
               state_nxt = HUNT;
`endif
            end
            default: state_nxt = HUNT;
         endcase
      end else if (state != HUNT && tmo_exp) begin
         state_nxt = HUNT;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= HUNT;
         idx     <= '0;
         addr_sh <= '0;
         data_sh <= '0;
         tmo     <= '0;
         wr_addr <= '0;
         wr_data <= '0;
`ifdef SERIAL_RX_CHECKSUM_EN
         chk_acc   <= '0;
         chk_err_q <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         addr_sh <= addr_nxt;
         data_sh <= data_nxt;
         if (state == HUNT || rx_valid) tmo <= 32'd0;
         else if (!tmo_exp)             tmo <= tmo + 32'd1;
         // load the port from the next-values so it is stable in the wr_en cycle
         if (state_nxt == WRITE) begin
            wr_addr <= addr_nxt;
            wr_data <= data_nxt;
         end
`ifdef SERIAL_RX_CHECKSUM_EN
         chk_acc   <= chk_nxt;
         chk_err_q <= chk_fail;
`endif
      end
   end

   assign wr_en = (state == WRITE);
   // busy drops as the write issues, so it never overlaps wr_en
   assign busy  = (state != HUNT) && (state != WRITE);
`ifdef SERIAL_RX_CHECKSUM_EN
   assign chk_err = chk_err_q;
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_loader.sv
// Directed bench for serial_rx_loader: frames, checksum, framing error, glitch, timeout, mid-frame reset.
// Runs at BAUD = 1 Mbaud (bit period 25 cycles) to keep the run short.
module tb_serial_rx_loader;

   localparam int CLK_HZ = 25000000;
   localparam int BAUD   = 1000000;
   localparam int BIT    = (CLK_HZ + BAUD / 2) / BAUD;
`ifdef SERIAL_RX_CHECKSUM_EN
   localparam int FRAME_LEN = 9;
   localparam int CE_EXP    = 1;
`else
   localparam int FRAME_LEN = 8;
   localparam int CE_EXP    = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rxd = 1'b1;
   logic        wr_en, rx_valid, busy, frame_err, chk_err;
   logic [16:0] wr_addr;
   logic [31:0] wr_data;
   logic [7:0]  rx_byte;

   int n_checks = 0, n_fail = 0;
   int cyc = 0, rx_cnt = 0, wr_cnt = 0, fe_cnt = 0, ce_cnt = 0;
   int last_rv = 0, wr_gap = 0, tx_start = 0, last_lat = 0;
   int w0, r0;
   logic        busy_at_wr = 1'b1;
   logic [16:0] cap_addr = '0;
   logic [31:0] cap_data = '0;

   serial_rx_loader #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(17), .TIMEOUT_BITS(32)
   ) dut (
      .clk(clk), .reset(reset), .rxd(rxd),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rx_valid(rx_valid), .rx_byte(rx_byte), .busy(busy),
      .frame_err(frame_err), .chk_err(chk_err)
   );

   always #20 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (rx_valid) begin
         rx_cnt++;
         last_rv  = cyc;
         last_lat = cyc - tx_start;
      end
      if (wr_en) begin
         wr_cnt++;
         wr_gap     = cyc - last_rv;
         busy_at_wr = busy;
         cap_addr   = wr_addr;
         cap_data   = wr_data;
      end
      if (frame_err) fe_cnt++;
      if (chk_err)   ce_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      tx_start = cyc;
      rxd = 1'b0;
      idle(BIT);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         idle(BIT);
      end
      rxd = stop_bit;
      idle(BIT);
      rxd = 1'b1;
   endtask

   task automatic send_frame(input logic [23:0] addr, input logic [31:0] data, input logic [7:0] chk);
      send_byte(8'hA5, 1'b1);
      send_byte(addr[23:16], 1'b1);
      send_byte(addr[15:8], 1'b1);
      send_byte(addr[7:0], 1'b1);
      send_byte(data[7:0], 1'b1);
      send_byte(data[15:8], 1'b1);
      send_byte(data[23:16], 1'b1);
      send_byte(data[31:24], 1'b1);
`ifdef SERIAL_RX_CHECKSUM_EN
      send_byte(chk, 1'b1);
`else
      if (chk === 8'hxx) $display("unused checksum");
`endif
   endtask

   initial begin
      #(200000 * 40);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #5 reset = 1'b0;
      idle(10);
      check("rst_wr_en", wr_en, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_chk_err", chk_err, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_rx_byte", rx_byte, 0);
      reset = 1'b1;
      idle(BIT);

      // basic frame
      send_frame(24'h001234, 32'hDEADBEEF, 8'h04);
      idle(BIT);
      check("f1_wr_count", wr_cnt, 1);
      check("f1_wr_addr", cap_addr, 17'h01234);
      check("f1_wr_data", cap_data, 32'hDEADBEEF);
      check("f1_busy_at_wr", busy_at_wr, 0);
      check("f1_wr_gap", wr_gap, 1);
      check("f1_rx_count", rx_cnt, FRAME_LEN);
`ifdef SERIAL_RX_CHECKSUM_EN
      check("f1_rx_byte", rx_byte, 8'h04);
`else
      check("f1_rx_byte", rx_byte, 8'hDE);
`endif
      check("f1_rx_latency", 32'(last_lat >= 9 * BIT + BIT / 2 + 1 && last_lat <= 9 * BIT + BIT / 2 + 6), 1);
      check("f1_busy_after", busy, 0);
      check("f1_hold_addr", wr_addr, 17'h01234);

`ifdef SERIAL_RX_CHECKSUM_EN
      w0 = wr_cnt;
      send_frame(24'h001234, 32'hDEADBEEF, 8'h05);
      idle(BIT);
      check("chk_bad_err", ce_cnt, 1);
      check("chk_bad_no_wr", wr_cnt - w0, 0);
      check("chk_bad_hold_data", wr_data, 32'hDEADBEEF);
      send_frame(24'h000005, 32'h12345678, 8'h0D);
      idle(BIT);
      check("chk_good_wr", wr_cnt - w0, 1);
      check("chk_good_data", cap_data, 32'h12345678);
`endif

      // stop bit of third byte low
      w0 = wr_cnt;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h12, 1'b0);
      idle(2 * BIT);
      check("fe_count", fe_cnt, 1);
      check("fe_no_wr", wr_cnt - w0, 0);
      check("fe_busy", busy, 0);
      send_frame(24'h010007, 32'h44332211, 8'h42);
      idle(BIT);
      check("fe_next_wr", wr_cnt - w0, 1);
      check("fe_next_addr", cap_addr, 17'h10007);
      check("fe_next_data", cap_data, 32'h44332211);

      // short low glitch, then garbage bytes
      r0 = rx_cnt;
      w0 = wr_cnt;
      rxd = 1'b0;
      idle(BIT / 4);
      rxd = 1'b1;
      idle(3 * BIT);
      check("glitch_no_rx", rx_cnt - r0, 0);
      check("glitch_no_fe", fe_cnt, 1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h5A, 1'b1);
      idle(BIT);
      check("garbage_rx_count", rx_cnt - r0, 3);
      check("garbage_rx_byte", rx_byte, 8'h5A);
      check("garbage_busy", busy, 0);
      send_frame(24'h000005, 32'h12345678, 8'h0D);
      idle(BIT);
      check("garbage_next_wr", wr_cnt - w0, 1);
      check("garbage_next_addr", cap_addr, 17'h00005);

      // partial frame, then inter-byte timeout
      w0 = wr_cnt;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h12, 1'b1);
      check("tmo_busy_mid", busy, 1);
      idle(40 * BIT);
      check("tmo_busy_after", busy, 0);
      check("tmo_no_wr", wr_cnt - w0, 0);
      send_frame(24'h000009, 32'hDDCCBBAA, 8'h09);
      idle(BIT);
      check("tmo_next_wr", wr_cnt - w0, 1);
      check("tmo_next_addr", cap_addr, 17'h00009);
      check("tmo_next_data", cap_data, 32'hDDCCBBAA);

      // reset during the fifth byte
      w0 = wr_cnt;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h0A, 1'b1);
      rxd = 1'b0;
      idle(3 * BIT);
      reset = 1'b0;
      idle(5);
      check("midrst_busy", busy, 0);
      check("midrst_wr_en", wr_en, 0);
      check("midrst_rx_valid", rx_valid, 0);
      check("midrst_frame_err", frame_err, 0);
      check("midrst_chk_err", chk_err, 0);
      check("midrst_wr_addr", wr_addr, 0);
      check("midrst_wr_data", wr_data, 0);
      check("midrst_rx_byte", rx_byte, 0);
      rxd = 1'b1;
      idle(BIT);
      reset = 1'b1;
      idle(2 * BIT);
      check("postrst_no_wr", wr_cnt - w0, 0);
      check("postrst_busy", busy, 0);
      send_frame(24'h00000A, 32'h04030201, 8'h0E);
      idle(BIT);
      check("postrst_wr", wr_cnt - w0, 1);
      check("postrst_addr", cap_addr, 17'h0000A);
      check("postrst_data", cap_data, 32'h04030201);
      check("chk_err_total", ce_cnt, CE_EXP);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
